uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side elastic buffer sitting directly downstream of the UART receiver. It accepts received characters and their error flags over an AXI-Stream slave port, stores them in a first-word-fall-through FIFO, and presents them to the host-side consumer over an AXI-Stream master port. The UART receiver cannot be stalled, so the FIFO never back-pressures it. Instead it drops on overflow, optionally discards errored characters, and keeps saturating statistics counters for the host.

## Interface
- DATA_WIDTH, 8, character width; matches the receiver's data width.
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 entries (16); legal range 1..10.
- DROP_ERRORS, 0, 1 = characters flagged with error are counted but not stored; 0 = stored with the flag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  DATA_WIDTH  received character
- s_axis_tvalid  in  1  character valid
- s_axis_tready  out  1  always 1 except while rst is high
- s_axis_terror  in  1  framing/parity error flag for the character
- m_axis_tdata  out  DATA_WIDTH  head-of-FIFO character
- m_axis_tvalid  out  1  FIFO not empty
- m_axis_tready  in  1  consumer accepts head
- m_axis_terror  out  1  error flag stored with the head entry
- count  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
- full  out  1  count == 2^DEPTH_LOG2
- empty  out  1  count == 0
- overflow_cnt  out  16  characters dropped because FIFO full; saturates at 0xFFFF
- error_cnt  out  16  characters received with s_axis_terror=1; saturates at 0xFFFF
- clear_stats  in  1  single-cycle pulse, zeroes both counters

## Operation
- Storage: 2^DEPTH_LOG2 entries × (DATA_WIDTH+1) bits, holding {terror, tdata}.
- Read and write pointers are DEPTH_LOG2+1 bits wide. The low DEPTH_LOG2 bits address memory and the MSB disambiguates full from empty. Both wrap naturally modulo 2^(DEPTH_LOG2+1).
- Push request: s_axis_tvalid & s_axis_tready.
- Pop: m_axis_tvalid & m_axis_tready.
- Store condition: push request & ~(DROP_ERRORS & s_axis_terror) & (~full | pop).
  - Full with a simultaneous pop: the write is accepted, count is unchanged, and no overflow is recorded.
- Overflow: push request & full & ~pop & store-eligible increments overflow_cnt (saturating).
  - A character discarded by DROP_ERRORS is never counted as an overflow.
- Error count: push request & s_axis_terror increments error_cnt (saturating), whether the character is stored or dropped, and whether or not the FIFO overflows.
- clear_stats has priority over a same-cycle increment; the counter reads 0 next cycle.
- Output is FWFT:
  - m_axis_tdata and m_axis_terror reflect mem[rd_ptr] whenever m_axis_tvalid=1.
  - They are stable until popped.
  - Their value while m_axis_tvalid=0 is don't-care.
- count increments on store-only, decrements on pop-only, and is unchanged on both or neither.
- full and empty are derived from the registered pointers. They are never combinational from the s_/m_ inputs.

## Timing
- Reset, synchronous: pointers=0, count=0, empty=1, full=0, m_axis_tvalid=0, overflow_cnt=0, error_cnt=0, s_axis_tready=0 while rst=1. Memory contents are not reset.
- Reset asserted mid-operation discards all stored entries on that edge; statistics are also cleared.
- Write latency: a character stored at edge N is visible on m_axis_* with m_axis_tvalid=1 in the cycle after edge N.
- Pop at edge N: the next entry, if any, is presented in the cycle after edge N. Back-to-back pops deliver 1 character per clock.
- Empty FIFO with push at edge N: no same-cycle bypass. m_axis_tvalid rises only after edge N.
- Counters, count, full and empty all update on the same edge as the triggering event.
- m_axis_tdata must not change while m_axis_tvalid=1 and m_axis_tready=0.

## Test plan
- Basic flow: push 0x41, 0x42, 0x43 with m_axis_tready=0, then raise tready. Require 0x41, 0x42, 0x43 on consecutive cycles, count 3→0, empty=1 at end, no counter changes.
- Overflow (DEPTH_LOG2=4): push 0x00..0x13 (20 chars) with m_axis_tready=0. Require full=1, count=16, overflow_cnt=4; draining yields 0x00..0x0F in order.
- Full with simultaneous pop: fill to 16, then push 0xAA in the same cycle as a pop. Require count stays 16, overflow_cnt=0, and 0xAA is the last character drained.
- Errors: push 0x55 with terror=1, then 0x66 with terror=0.
  - DROP_ERRORS=0: output 0x55 with m_axis_terror=1, then 0x66 with m_axis_terror=0, error_cnt=1.
  - DROP_ERRORS=1: output only 0x66, error_cnt=1, overflow_cnt=0.
- Saturation and clear: force 65540 overflows. Require overflow_cnt=0xFFFF. Pulse clear_stats in the same cycle as a further overflow. Require overflow_cnt=0 next cycle.
- Reset mid-stream and wrap: with 5 entries queued, assert rst for one cycle. Require empty=1, m_axis_tvalid=0, counters 0. Then stream 40 characters with m_axis_tready=1 (pointer wrap ×2). Require in-order delivery with no loss.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receive elastic buffer: FWFT FIFO that never stalls the receiver,
// with drop-on-overflow, optional error discard and saturating statistics.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   s_axis_*         - characters + error flag from the UART receiver
//   m_axis_*         - head-of-FIFO character + error flag to the host
//   count/full/empty - occupancy status derived from registered state
//   overflow_cnt     - characters dropped on full (saturating)
//   error_cnt        - characters received with an error flag (saturating)
//   clear_stats      - one-cycle pulse zeroing both statistics counters
module uart_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_LOG2  = 4,
    parameter int DROP_ERRORS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_terror,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_terror,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic [15:0]           overflow_cnt,
    output logic [15:0]           error_cnt,
    input  logic                  clear_stats
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] ONE = PW'(1);
    localparam bit DROP = (DROP_ERRORS != 0);

    logic [DATA_WIDTH:0] mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       count_q, count_d;
    logic [15:0]         ovf_q, ovf_d;
    logic [15:0]         err_q, err_d;

    logic push_req, pop, eligible, store, ovf_ev, err_ev;
    logic [DATA_WIDTH:0] head;

    // Full/empty come from the pointers only: same address, MSB tells which.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

    assign s_axis_tready = ~rst;
    assign m_axis_tvalid = ~empty;

    assign push_req = s_axis_tvalid & s_axis_tready;
    assign pop      = m_axis_tvalid & m_axis_tready;
    assign eligible = ~(DROP & s_axis_terror);
    // A pop frees the head slot on this edge, so a full FIFO may still store.
    assign store    = push_req & eligible & (~full | pop);
    assign ovf_ev   = push_req & eligible & full & ~pop;
    assign err_ev   = push_req & s_axis_terror;

    assign head          = mem_q[rd_ptr_q[PW-2:0]];
    assign m_axis_tdata  = head[DATA_WIDTH-1:0];
    assign m_axis_terror = head[DATA_WIDTH];

    assign count        = count_q;
    assign overflow_cnt = ovf_q;
    assign error_cnt    = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        err_d    = err_q;

        if (store) wr_ptr_d = wr_ptr_q + ONE;
        if (pop)   rd_ptr_d = rd_ptr_q + ONE;

        if (store && !pop)      count_d = count_q + ONE;
        else if (pop && !store) count_d = count_q - ONE;

        if (clear_stats)                    ovf_d = '0;
        else if (ovf_ev && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;

        if (clear_stats)                    err_d = '0;
        else if (err_ev && err_q != 16'hFFFF) err_d = err_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q[PW-2:0]] <= {s_axis_terror, s_axis_tdata};
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven flow/error vectors
// plus directed overflow, full-with-pop, saturation and reset/wrap sequences.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_terror, m_tready, clear_stats;

    logic        s_tready, m_tvalid, m_terror, full, empty;
    logic [7:0]  m_tdata;
    logic [4:0]  count;
    logic [15:0] ovf_cnt, err_cnt;

    logic        d_s_tready, d_m_tvalid, d_m_terror, d_full, d_empty;
    logic [7:0]  d_m_tdata;
    logic [4:0]  d_count;
    logic [15:0] d_ovf_cnt, d_err_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4), .DROP_ERRORS(0)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_terror(s_terror),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_terror(m_terror),
        .count(count), .full(full), .empty(empty),
        .overflow_cnt(ovf_cnt), .error_cnt(err_cnt),
        .clear_stats(clear_stats)
    );

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4), .DROP_ERRORS(1)) dut_drop (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(d_s_tready), .s_axis_terror(s_terror),
        .m_axis_tdata(d_m_tdata), .m_axis_tvalid(d_m_tvalid),
        .m_axis_tready(m_tready), .m_axis_terror(d_m_terror),
        .count(d_count), .full(d_full), .empty(d_empty),
        .overflow_cnt(d_ovf_cnt), .error_cnt(d_err_cnt),
        .clear_stats(clear_stats)
    );

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       se;
        logic       mr;
        logic       ev;
        logic [7:0] ed;
        logic       ee;
        logic [4:0] ec;
        logic [15:0] eerr;
        logic       dv;
        logic [7:0] dd;
        logic [4:0] dc;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tdata = 8'h00;
        s_terror = 1'b0;
        m_tready = 1'b0;
        clear_stats = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic e, input logic r);
        s_tvalid = 1'b1;
        s_tdata = d;
        s_terror = e;
        m_tready = r;
        step();
        idle();
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 5'd1, 16'd0, 1'b1, 8'h41, 5'd1};
        tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 5'd2, 16'd0, 1'b1, 8'h41, 5'd2};
        tbl[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 5'd3, 16'd0, 1'b1, 8'h41, 5'd3};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 5'd2, 16'd0, 1'b1, 8'h42, 5'd2};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h43, 1'b0, 5'd1, 16'd0, 1'b1, 8'h43, 5'd1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 16'd0, 1'b0, 8'h00, 5'd0};
        tbl[6] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 5'd1, 16'd1, 1'b0, 8'h00, 5'd0};
        tbl[7] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 5'd2, 16'd1, 1'b1, 8'h66, 5'd1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 5'd1, 16'd1, 1'b0, 8'h00, 5'd0};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 16'd1, 1'b0, 8'h00, 5'd0};

        idle();
        rst = 1'b1;
        step();
        step();
        chk("rst_tready", {31'd0, s_tready}, 32'd0);
        chk("rst_valid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_ovf", {16'd0, ovf_cnt}, 32'd0);
        chk("rst_err", {16'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        chk("tready_up", {31'd0, s_tready}, 32'd1);

        // Basic flow and error handling, both DROP_ERRORS settings
        for (int i = 0; i < 10; i++) begin
            s_tvalid = tbl[i].sv;
            s_tdata = tbl[i].sd;
            s_terror = tbl[i].se;
            m_tready = tbl[i].mr;
            step();
            idle();
            chk($sformatf("v%0d_valid", i), {31'd0, m_tvalid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_data", i), {24'd0, m_tdata}, {24'd0, tbl[i].ed});
                chk($sformatf("v%0d_terr", i), {31'd0, m_terror}, {31'd0, tbl[i].ee});
            end
            chk($sformatf("v%0d_count", i), {27'd0, count}, {27'd0, tbl[i].ec});
            chk($sformatf("v%0d_empty", i), {31'd0, empty}, {31'd0, tbl[i].ec == 5'd0});
            chk($sformatf("v%0d_full", i), {31'd0, full}, 32'd0);
            chk($sformatf("v%0d_errcnt", i), {16'd0, err_cnt}, {16'd0, tbl[i].eerr});
            chk($sformatf("v%0d_ovf", i), {16'd0, ovf_cnt}, 32'd0);
            chk($sformatf("v%0d_d_valid", i), {31'd0, d_m_tvalid}, {31'd0, tbl[i].dv});
            if (tbl[i].dv)
                chk($sformatf("v%0d_d_data", i), {24'd0, d_m_tdata}, {24'd0, tbl[i].dd});
            chk($sformatf("v%0d_d_count", i), {27'd0, d_count}, {27'd0, tbl[i].dc});
            chk($sformatf("v%0d_d_errcnt", i), {16'd0, d_err_cnt}, {16'd0, tbl[i].eerr});
            chk($sformatf("v%0d_d_ovf", i), {16'd0, d_ovf_cnt}, 32'd0);
        end

        // Overflow: 20 pushes into 16 entries
        do_reset();
        for (int i = 0; i < 20; i++) push(8'(i), 1'b0, 1'b0);
        chk("ovf_full", {31'd0, full}, 32'd1);
        chk("ovf_count", {27'd0, count}, 32'd16);
        chk("ovf_cnt", {16'd0, ovf_cnt}, 32'd4);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_drain%0d", i), {23'd0, m_tvalid, m_tdata}, {23'd0, 1'b1, 8'(i)});
            m_tready = 1'b1;
            step();
        end
        m_tready = 1'b0;
        chk("ovf_empty", {31'd0, empty}, 32'd1);

        // Full with simultaneous pop
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0, 1'b0);
        push(8'hAA, 1'b0, 1'b1);
        chk("fp_count", {27'd0, count}, 32'd16);
        chk("fp_full", {31'd0, full}, 32'd1);
        chk("fp_ovf", {16'd0, ovf_cnt}, 32'd0);
        for (int i = 1; i < 17; i++) begin
            chk($sformatf("fp_drain%0d", i), {23'd0, m_tvalid, m_tdata},
                {23'd0, 1'b1, (i == 16) ? 8'hAA : 8'(i)});
            m_tready = 1'b1;
            step();
        end
        m_tready = 1'b0;
        chk("fp_empty", {31'd0, empty}, 32'd1);

        // Saturation and clear priority
        do_reset();
        s_tvalid = 1'b1;
        for (int i = 0; i < 16 + 65540; i++) begin
            s_tdata = 8'(i);
            step();
        end
        chk("sat_ovf", {16'd0, ovf_cnt}, 32'h0000FFFF);
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        chk("clr_ovf", {16'd0, ovf_cnt}, 32'd0);
        step();
        chk("post_clr_ovf", {16'd0, ovf_cnt}, 32'd1);
        idle();

        // Reset mid-stream, then wrap the pointers twice
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i), 1'b1, 1'b0);
        chk("pre_count", {27'd0, count}, 32'd5);
        chk("pre_err", {16'd0, err_cnt}, 32'd5);
        rst = 1'b1;
        step();
        chk("mid_empty", {31'd0, empty}, 32'd1);
        chk("mid_valid", {31'd0, m_tvalid}, 32'd0);
        chk("mid_err", {16'd0, err_cnt}, 32'd0);
        chk("mid_ovf", {16'd0, ovf_cnt}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            s_tvalid = 1'b1;
            s_tdata = 8'(8'h80 + i);
            m_tready = 1'b1;
            step();
            chk($sformatf("wrap%0d", i), {18'd0, m_tvalid, count, m_tdata},
                {18'd0, 1'b1, 5'd1, 8'(8'h80 + i)});
        end
        s_tvalid = 1'b0;
        step();
        idle();
        chk("wrap_empty", {31'd0, empty}, 32'd1);
        chk("wrap_ovf", {16'd0, ovf_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
